hazard_scoreboard: RTL and testbench

- Parametrised hazard and interlock unit for the in-order MIPS pipeline, sitting beside the ID stage.
- Keeps a shift register of pending destination-register tags, one entry per downstream stage.
- From those tags it decides stalls, bubbles, flushes and (optionally) forwarding selects.
- Generalises the fixed EX/MEM compare to NSTAGES tracked stages, a configurable redirect stage, memory-wait freeze, and a stall-cycle counter.

---
 rtl/hazard_scoreboard.sv | 139 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending-destination tag pipe beside the ID stage of an
// in-order MIPS pipeline. Decides PC/IF-ID enables, flushes, bubbles, an
// optional forwarding select and counts data-stall cycles.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding with load-use stall
// only). Without it the unit is stall-only and the fwd outputs are tied to 0.
module hazard_scoreboard #(
    parameter int unsigned NSTAGES     = 3,
    parameter int unsigned REDIR_STAGE = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FW          = $clog2(NSTAGES + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic             id_wr_i,
    input  logic [4:0]       id_wsel_i,
    input  logic             id_load_i,
    input  logic             redirect_i,
    input  logic             mem_wait_i,
    output logic             pc_en_o,
    output logic             id_en_o,
    output logic             id_flush_o,
    output logic             ex_flush_o,
    output logic [FW-1:0]    fwd_rs_o,
    output logic [FW-1:0]    fwd_rt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int N  = int'(NSTAGES);
    localparam int RS = int'(REDIR_STAGE);

    typedef struct packed {
        logic       v;
        logic [4:0] wsel;
        logic       ld;
    } tag_t;

    tag_t             pipe     [1:N];
    tag_t             pipe_nxt [1:N];
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_nxt;
    logic             data_stall;
    logic             load_use;

    // A tag matches an ID source when the source is really read and not $zero
    function automatic logic hit_f(input tag_t t, input logic vld,
                                   input logic [4:0] r, input logic use_r);
        return vld && use_r && t.v && (t.wsel == r) && (r != 5'd0);
    endfunction

    // Consumer in ID depends on a load still in EX
    always_comb begin
        load_use = (hit_f(pipe[1], id_valid_i, id_rs_i, id_use_rs_i) ||
                    hit_f(pipe[1], id_valid_i, id_rt_i, id_use_rt_i)) && pipe[1].ld;
    end

`ifdef HAZARD_FORWARD_EN
    // Youngest matching entry supplies the operand; only load-use must wait
    always_comb begin
        fwd_rs_o   = '0;
        fwd_rt_o   = '0;
        data_stall = load_use;
        for (int k = N; k >= 1; k--) begin
            if (hit_f(pipe[k], id_valid_i, id_rs_i, id_use_rs_i)) fwd_rs_o = FW'(k);
            if (hit_f(pipe[k], id_valid_i, id_rt_i, id_use_rt_i)) fwd_rt_o = FW'(k);
        end
    end
`else
    // Stall until the producer reaches the write-before-read WB entry
    always_comb begin
        fwd_rs_o   = '0;
        fwd_rt_o   = '0;
        data_stall = (N > 1) && load_use;
        for (int k = 1; k < N; k++) begin
            if (hit_f(pipe[k], id_valid_i, id_rs_i, id_use_rs_i) ||
                hit_f(pipe[k], id_valid_i, id_rt_i, id_use_rt_i)) data_stall = 1'b1;
        end
    end
`endif

    // Pipeline control outputs in priority order: freeze, redirect, stall
    always_comb begin
        pc_en_o    = 1'b1;
        id_en_o    = 1'b1;
        id_flush_o = 1'b0;
        ex_flush_o = 1'b0;
        if (mem_wait_i) begin
            pc_en_o = 1'b0;
            id_en_o = 1'b0;
        end else if (redirect_i) begin
            id_flush_o = 1'b1;
            ex_flush_o = 1'b1;
        end else if (data_stall) begin
            pc_en_o    = 1'b0;
            id_en_o    = 1'b0;
            ex_flush_o = 1'b1;
        end
    end

    // Next tag pipe and stall counter
    always_comb begin
        for (int k = 1; k <= N; k++) pipe_nxt[k] = pipe[k];
        stall_cnt_nxt = stall_cnt;
        if (!mem_wait_i) begin
            for (int k = N; k >= 2; k--) pipe_nxt[k] = pipe[k - 1];
            pipe_nxt[1] = '0;
            if (redirect_i) begin
                // Entries younger than the redirecting instruction are wrong-path
                for (int k = 2; k <= N; k++) begin
                    if (k - 1 < RS) pipe_nxt[k].v = 1'b0;
                end
            end else if (data_stall) begin
                if (stall_cnt != '1) stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end else begin
                pipe_nxt[1].v    = id_valid_i && id_wr_i && (id_wsel_i != 5'd0);
                pipe_nxt[1].wsel = id_wsel_i;
                pipe_nxt[1].ld   = id_load_i;
            end
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 1; k <= N; k++) pipe[k] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int k = 1; k <= N; k++) pipe[k] <= pipe_nxt[k];
            stall_cnt <= stall_cnt_nxt;
        end
    end

    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector tables plus randomized
// traffic checked against an age-based in-flight instruction model.
module tb_hazard_scoreboard;

    localparam int N  = 3;
    localparam int R  = 2;
    localparam int FW = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       wr;
        logic [4:0] wsel;
        logic       ld;
        logic       redir;
        logic       mwait;
    } in_t;

    typedef struct packed {
        logic          pc;
        logic          id;
        logic          idf;
        logic          exf;
        logic [FW-1:0] fr;
        logic [FW-1:0] ft;
        logic [15:0]   cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    typedef struct {
        int         age;
        logic [4:0] w;
        logic       ld;
    } fl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_use_rs, id_use_rt, id_wr, id_load, redirect, mem_wait;
    logic [4:0] id_rs, id_rt, id_wsel;
    logic pc_en, id_en, id_flush, ex_flush;
    logic [FW-1:0] fwd_rs, fwd_rt;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    fl_t fl[$];
    int m_cnt = 0;
    vec_t tbl[$];

    hazard_scoreboard dut (
        .CLK(clk), .nRST(rst_n),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_wr_i(id_wr), .id_wsel_i(id_wsel), .id_load_i(id_load),
        .redirect_i(redirect), .mem_wait_i(mem_wait),
        .pc_en_o(pc_en), .id_en_o(id_en), .id_flush_o(id_flush), .ex_flush_o(ex_flush),
        .fwd_rs_o(fwd_rs), .fwd_rt_o(fwd_rt), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mki(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                logic wr, logic [4:0] ws, logic ld, logic rd, logic mw);
        in_t s;
        s.valid = v; s.rs = rs; s.rt = rt; s.use_rs = urs; s.use_rt = urt;
        s.wr = wr; s.wsel = ws; s.ld = ld; s.redir = rd; s.mwait = mw;
        return s;
    endfunction

    function automatic out_t mko(logic pc, logic id, logic idf, logic exf,
                                 int fr, int ft, int cnt);
        out_t o;
        o.pc = pc; o.id = id; o.idf = idf; o.exf = exf;
        o.fr = FW'(fr); o.ft = FW'(ft); o.cnt = 16'(cnt);
        return o;
    endfunction

    // Expected outputs: find the youngest in-flight writer of each source
    function automatic out_t model_eval(in_t s, output bit stall);
        out_t o;
        int ar = N + 1, at = N + 1;
        bit lr = 0, lt = 0;
        foreach (fl[j]) begin
            if (s.valid && s.use_rs && s.rs != 0 && fl[j].w == s.rs && fl[j].age < ar) begin
                ar = fl[j].age; lr = fl[j].ld;
            end
            if (s.valid && s.use_rt && s.rt != 0 && fl[j].w == s.rt && fl[j].age < at) begin
                at = fl[j].age; lt = fl[j].ld;
            end
        end
`ifdef HAZARD_FORWARD_EN
        stall = (ar == 1 && lr) || (at == 1 && lt);
        o.fr = (ar <= N) ? FW'(ar) : '0;
        o.ft = (at <= N) ? FW'(at) : '0;
`else
        stall = (ar < N) || (at < N);
        o.fr = '0;
        o.ft = '0;
`endif
        o.idf = 0; o.exf = 0; o.pc = 1; o.id = 1;
        if (s.mwait) begin
            o.pc = 0; o.id = 0;
        end else if (s.redir) begin
            o.idf = 1; o.exf = 1;
        end else if (stall) begin
            o.pc = 0; o.id = 0; o.exf = 1;
        end
        o.cnt = 16'(m_cnt);
        return o;
    endfunction

    // Advance the model by one clock: age everything, drop retired/wrong-path
    function automatic void model_update(in_t s, bit stall);
        fl_t keep[$];
        fl_t n;
        if (s.mwait) return;
        foreach (fl[j]) begin
            n = fl[j];
            n.age = n.age + 1;
            if (n.age <= N && !(s.redir && n.age <= R)) keep.push_back(n);
        end
        fl = keep;
        if (s.redir) return;
        if (stall) begin
            if (m_cnt < 65535) m_cnt++;
        end else if (s.valid && s.wr && s.wsel != 0) begin
            n.age = 1; n.w = s.wsel; n.ld = s.ld;
            fl.push_back(n);
        end
    endfunction

    function automatic out_t sample();
        out_t o;
        o.pc = pc_en; o.id = id_en; o.idf = id_flush; o.exf = ex_flush;
        o.fr = fwd_rs; o.ft = fwd_rt; o.cnt = stall_cnt;
        return o;
    endfunction

    task automatic apply(in_t s);
        id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
        id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_wr = s.wr;
        id_wsel = s.wsel; id_load = s.ld; redirect = s.redir; mem_wait = s.mwait;
    endtask

    // One cycle: drive at negedge, compare against the model, then let the edge pass
    task automatic step(in_t s, output out_t act);
        out_t exp;
        bit st;
        @(negedge clk);
        apply(s);
        #2;
        exp = model_eval(s, st);
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model t=%0t got=%h exp=%h", $time, act, exp);
        end
        model_update(s, st);
    endtask

    task automatic do_reset();
        out_t act;
        @(negedge clk);
        rst_n = 1'b0;
        apply(mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        fl.delete();
        m_cnt = 0;
        #2;
        act = sample();
        checks++;
        if (act !== mko(1, 1, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", act, mko(1, 1, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        out_t act;
        in_t  s;
        in_t  idle;
        idle = mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(idle);
        #12;
        do_reset();

`ifdef HAZARD_FORWARD_EN
        tbl.push_back({mki(1, 1, 2, 1, 1, 1, 3, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 0)});
        tbl.push_back({mki(1, 3, 5, 1, 1, 1, 4, 0, 0, 0), mko(1, 1, 0, 0, 1, 0, 0)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 0)});
        tbl.push_back({mki(1, 1, 0, 1, 0, 1, 2, 1, 0, 0), mko(1, 1, 0, 0, 0, 0, 0)});
        tbl.push_back({mki(1, 2, 2, 1, 1, 1, 6, 0, 0, 0), mko(0, 0, 0, 1, 1, 1, 0)});
        tbl.push_back({mki(1, 2, 2, 1, 1, 1, 6, 0, 0, 0), mko(1, 1, 0, 0, 2, 2, 1)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 1)});
        tbl.push_back({mki(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 1)});
        tbl.push_back({mki(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 1)});
`else
        tbl.push_back({mki(1, 1, 2, 1, 1, 1, 3, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 0)});
        tbl.push_back({mki(1, 3, 5, 1, 1, 1, 4, 0, 0, 0), mko(0, 0, 0, 1, 0, 0, 0)});
        tbl.push_back({mki(1, 3, 5, 1, 1, 1, 4, 0, 0, 0), mko(0, 0, 0, 1, 0, 0, 1)});
        tbl.push_back({mki(1, 3, 5, 1, 1, 1, 4, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 1, 2, 1, 1, 1, 7, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 7, 0, 1, 0, 1, 9, 0, 1, 0), mko(1, 1, 1, 1, 0, 0, 2)});
        tbl.push_back({mki(1, 7, 0, 1, 0, 1, 9, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 1, 2, 1, 1, 1, 8, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 0, 8, 0, 1, 0, 0, 0, 0, 1), mko(0, 0, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 0, 8, 0, 1, 0, 0, 0, 0, 1), mko(0, 0, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 0, 8, 0, 1, 0, 0, 0, 0, 1), mko(0, 0, 0, 0, 0, 0, 2)});
        tbl.push_back({mki(1, 0, 8, 0, 1, 0, 0, 0, 0, 0), mko(0, 0, 0, 1, 0, 0, 2)});
        tbl.push_back({mki(1, 0, 8, 0, 1, 0, 0, 0, 0, 0), mko(0, 0, 0, 1, 0, 0, 3)});
        tbl.push_back({mki(1, 0, 8, 0, 1, 0, 0, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 4)});
        tbl.push_back({mki(1, 0, 0, 0, 0, 1, 0, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 4)});
        tbl.push_back({mki(1, 0, 0, 1, 1, 0, 0, 0, 0, 0), mko(1, 1, 0, 0, 0, 0, 4)});
        tbl.push_back({idle,                              mko(1, 1, 0, 0, 0, 0, 4)});
`endif

        foreach (tbl[k]) begin
            step(tbl[k].i, act);
            checks++;
            if (act !== tbl[k].e) begin
                failures++;
                $display("FAIL table[%0d] got=%h exp=%h", k, act, tbl[k].e);
            end
        end

        // Mid-stream reset: a producer is in flight, then reset clears it
        step(mki(1, 1, 2, 1, 1, 1, 5, 1, 0, 0), act);
        do_reset();
        step(mki(1, 5, 5, 1, 1, 0, 0, 0, 0, 0), act);
        checks++;
        if (act !== mko(1, 1, 0, 0, 0, 0, 0)) begin
            failures++;
            $display("FAIL post_reset got=%h exp=%h", act, mko(1, 1, 0, 0, 0, 0, 0));
        end

        // Random traffic over a small register set to provoke frequent hits
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            s.valid  = ($urandom_range(0, 9) != 0);
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.use_rs = 1'($urandom);
            s.use_rt = 1'($urandom);
            s.wr     = 1'($urandom);
            s.wsel   = 5'($urandom_range(0, 3));
            s.ld     = ($urandom_range(0, 2) == 0);
            s.redir  = ($urandom_range(0, 9) == 0);
            s.mwait  = ($urandom_range(0, 7) == 0);
            step(s, act);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
